game_vga_scan_out: RTL and testbench

- Raster timing master and pixel sink for the game display path.
- Counts a VGA frame and drives pixel_x/pixel_y into the sprite/background pipelines.
- Accepts their rgb_en/rgb back after a fixed pipeline latency, then aligns sync and blanking to that returned data.
- Drives the registered VGA pins and a once-per-frame vblank pulse for game logic.

---
 rtl/game_vga_scan_out_if.sv | 30 +++
 rtl/game_vga_scan_out.sv | 127 ++++++++++++
 tb/tb_game_vga_scan_out.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_vga_scan_out_if.sv
// rtl/game_vga_scan_out_if.sv - pixel coordinate / colour return bundle between scan-out and render pipelines
// Purpose: carries the coordinates issued by the raster timing master and the colour returned by the
//          sprite/background pipelines.
// Signals: pixel_x, pixel_y   - current raster coordinate (not clamped in blanking)
//          display_on         - coordinate lies in the visible area (undelayed)
//          vblank_pulse       - one cycle per frame at the start of vertical blanking
//          rgb_en, rgb        - colour returned by the pipeline, qualified by rgb_en
// Modports: master = scan-out block, slave = render pipeline.
interface game_vga_scan_out_if #(
   parameter int X_WIDTH   = 10,
   parameter int Y_WIDTH   = 10,
   parameter int RGB_WIDTH = 3
);
   logic [X_WIDTH-1:0]   pixel_x;
   logic [Y_WIDTH-1:0]   pixel_y;
   logic                 display_on;
   logic                 vblank_pulse;
   logic                 rgb_en;
   logic [RGB_WIDTH-1:0] rgb;

   modport master (
      output pixel_x, pixel_y, display_on, vblank_pulse,
      input  rgb_en, rgb
   );

   modport slave (
      input  pixel_x, pixel_y, display_on, vblank_pulse,
      output rgb_en, rgb
   );
endinterface

// File: rtl/game_vga_scan_out.sv
// rtl/game_vga_scan_out.sv - VGA raster timing master and registered pixel sink
// Purpose: counts a VGA frame, issues pixel coordinates to the render pipelines, delays sync and
//          blanking by the pipeline latency so they line up with the returned colour, and registers
//          the VGA pins.
// Ports:   clk          - pixel clock, one pixel per cycle
//          reset        - asynchronous active-low reset
//          pix          - coordinate/colour bundle (master side)
//          vga_hsync    - registered active-low horizontal sync
//          vga_vsync    - registered active-low vertical sync
//          vga_rgb      - registered pixel colour, forced to 0 in blanking
module game_vga_scan_out #(
   parameter int                   H_DISPLAY    = 640,
   parameter int                   H_FRONT      = 16,
   parameter int                   H_SYNC       = 96,
   parameter int                   H_BACK       = 48,
   parameter int                   V_DISPLAY    = 480,
   parameter int                   V_FRONT      = 10,
   parameter int                   V_SYNC       = 2,
   parameter int                   V_BACK       = 33,
   parameter int                   X_WIDTH      = 10,
   parameter int                   Y_WIDTH      = 10,
   parameter int                   RGB_WIDTH    = 3,
   parameter int                   PIPE_LATENCY = 2,
   parameter logic [RGB_WIDTH-1:0] BG_RGB       = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   game_vga_scan_out_if.master  pix,
   output logic                 vga_hsync,
   output logic                 vga_vsync,
   output logic [RGB_WIDTH-1:0] vga_rgb
);
   localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_DISPLAY + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_DISPLAY + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [X_WIDTH-1:0]   h_cnt_q, h_cnt_d;
   logic [Y_WIDTH-1:0]   v_cnt_q, v_cnt_d;
   logic                 h_wrap;
   logic                 hs_raw, vs_raw, de_raw;
   logic                 hs_d, vs_d, de_d;
   logic                 vga_hsync_q, vga_hsync_d;
   logic                 vga_vsync_q, vga_vsync_d;
   logic [RGB_WIDTH-1:0] vga_rgb_q, vga_rgb_d;

   // Raster counters: the vertical count advances only on the horizontal wrap, so the
   // end-of-frame transition to (0,0) happens in one cycle.
   always_comb begin
      h_wrap  = (h_cnt_q == X_WIDTH'(H_TOTAL - 1));
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = (v_cnt_q == Y_WIDTH'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end
   end

   assign de_raw = (h_cnt_q < X_WIDTH'(H_DISPLAY)) && (v_cnt_q < Y_WIDTH'(V_DISPLAY));
   assign hs_raw = !((h_cnt_q >= X_WIDTH'(HS_START)) && (h_cnt_q < X_WIDTH'(HS_END)));
   assign vs_raw = !((v_cnt_q >= Y_WIDTH'(VS_START)) && (v_cnt_q < Y_WIDTH'(VS_END)));

   assign pix.pixel_x    = h_cnt_q;
   assign pix.pixel_y    = v_cnt_q;
   assign pix.display_on = de_raw;
   // Counters sit at (0,0) in reset, but gate explicitly so the pulse cannot depend on that.
   assign pix.vblank_pulse = reset && (h_cnt_q == '0) && (v_cnt_q == Y_WIDTH'(V_DISPLAY));

   // Timing delay line so sync/blank match the colour coming back from the render pipelines.
   // Stage bits are {hs, vs, de}; reset to inactive syncs and blanked video so the flush after
   // reset release never produces a sync pulse.
   if (PIPE_LATENCY == 0) begin : g_no_dly
      assign {hs_d, vs_d, de_d} = {hs_raw, vs_raw, de_raw};
   end else begin : g_dly
      logic [2:0] dly_q [PIPE_LATENCY];
      logic [2:0] dly_d [PIPE_LATENCY];

      always_comb begin
         dly_d[0] = {hs_raw, vs_raw, de_raw};
         for (int i = 1; i < PIPE_LATENCY; i++) begin
            dly_d[i] = dly_q[i-1];
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
               dly_q[i] <= 3'b110;
            end
         end else begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
               dly_q[i] <= dly_d[i];
            end
         end
      end

      assign {hs_d, vs_d, de_d} = dly_q[PIPE_LATENCY-1];
   end

   // Colour outside the delayed display window is forced to black regardless of rgb_en.
   always_comb begin
      vga_hsync_d = hs_d;
      vga_vsync_d = vs_d;
      vga_rgb_d   = de_d ? (pix.rgb_en ? pix.rgb : BG_RGB) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         vga_hsync_q <= 1'b1;
         vga_vsync_q <= 1'b1;
         vga_rgb_q   <= '0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         vga_hsync_q <= vga_hsync_d;
         vga_vsync_q <= vga_vsync_d;
         vga_rgb_q   <= vga_rgb_d;
      end
   end

   assign vga_hsync = vga_hsync_q;
   assign vga_vsync = vga_vsync_q;
   assign vga_rgb   = vga_rgb_q;
endmodule

// File: tb/tb_game_vga_scan_out.sv
// tb/tb_game_vga_scan_out.sv - scoreboard bench for game_vga_scan_out on a reduced raster
`timescale 1ns/1ps
module tb_game_vga_scan_out;
   // Reduced raster: 16+4+6+6 = 32 clocks/line, 8+2+2+3 = 15 lines, 480 clocks/frame.
   // hsync low at h 20..25, vsync low at v 10..11, visible h<16 && v<8, vblank at k=8*32=256.
   localparam int HT    = 32;
   localparam int VT    = 15;
   localparam int FRAME = 480;
   localparam logic [2:0] BG = 3'd2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   game_vga_scan_out_if #(.X_WIDTH(10), .Y_WIDTH(10), .RGB_WIDTH(3)) if_a ();
   game_vga_scan_out_if #(.X_WIDTH(10), .Y_WIDTH(10), .RGB_WIDTH(3)) if_b ();

   logic       hs_a, vs_a, hs_b, vs_b;
   logic [2:0] rgb_a, rgb_b;

   game_vga_scan_out #(
      .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .X_WIDTH(10), .Y_WIDTH(10), .RGB_WIDTH(3), .PIPE_LATENCY(2), .BG_RGB(BG)
   ) dut_a (
      .clk(clk), .reset(reset), .pix(if_a),
      .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_rgb(rgb_a)
   );

   game_vga_scan_out #(
      .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .X_WIDTH(10), .Y_WIDTH(10), .RGB_WIDTH(3), .PIPE_LATENCY(0), .BG_RGB(BG)
   ) dut_b (
      .clk(clk), .reset(reset), .pix(if_b),
      .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_rgb(rgb_b)
   );

   typedef struct {
      int         due;
      logic [4:0] ea;
      logic [4:0] eb;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   k;
   int   mode;
   bit   run;
   int   checks;
   int   failures;
   int   fall_a, fall_b, hs_low_a, vs_low_a, vb_cnt, five_cnt, five_k;
   logic hs_a_prev, hs_b_prev;

   // Pipeline colour for coordinate index n: {rgb_en, rgb}
   function automatic logic [3:0] stim(int n, int md);
      int h, v;
      if (n < 0) return 4'b0000;
      h = n % HT;
      v = (n / HT) % VT;
      case (md)
         0:       return (h == 5 && v == 3) ? 4'b1101 : 4'b0011;
         1:       return 4'b1111;
         default: return 4'b0110;
      endcase
   endfunction

   // Expected pins {hsync, vsync, rgb} for coordinate index n (negative = still in reset flush)
   function automatic logic [4:0] pins(int n, int md);
      int h, v;
      logic hs, vs, de;
      logic [3:0] s;
      logic [2:0] c;
      if (n < 0) return 5'b11000;
      h  = n % HT;
      v  = (n / HT) % VT;
      hs = !(h >= 20 && h <= 25);
      vs = !(v >= 10 && v <= 11);
      de = (h < 16) && (v < 8);
      s  = stim(n, md);
      c  = !de ? 3'd0 : (s[3] ? s[2:0] : BG);
      return {hs, vs, c};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s k=%0d actual=%0h expected=%0h", name, k, act, exp);
      end
   endtask

   // Drive both pipelines for the current cycle and queue the pins they must produce next cycle.
   task automatic drive();
      logic [3:0] sa, sb;
      exp_t e;
      sa = stim(k - 2, mode);
      sb = stim(k, mode);
      if_a.rgb_en = sa[3];
      if_a.rgb    = sa[2:0];
      if_b.rgb_en = sb[3];
      if_b.rgb    = sb[2:0];
      e.due = k + 1;
      e.ea  = pins(k - 2, mode);
      e.eb  = pins(k, mode);
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
      drive();
   endtask

   task automatic start_phase(int md);
      @(posedge clk);
      #1;
      mode      = md;
      k         = 0;
      fall_a    = -1;
      fall_b    = -1;
      hs_low_a  = 0;
      vs_low_a  = 0;
      vb_cnt    = 0;
      five_cnt  = 0;
      five_k    = -1;
      hs_a_prev = 1'b1;
      hs_b_prev = 1'b1;
      q.delete();
      reset = 1'b1;
      drive();
      run = 1'b1;
   endtask

   task automatic chk_reset_pins(string tag);
      chk({tag, "_pins_a"}, 32'({hs_a, vs_a, rgb_a}), 32'h18);
      chk({tag, "_pins_b"}, 32'({hs_b, vs_b, rgb_b}), 32'h18);
      chk({tag, "_px"}, 32'(if_a.pixel_x), 0);
      chk({tag, "_py"}, 32'(if_a.pixel_y), 0);
      chk({tag, "_vblank"}, 32'(if_a.vblank_pulse), 0);
   endtask

   // Monitor: coordinate outputs against the cycle index, pins against the scoreboard queue.
   always @(negedge clk) begin
      if (run) begin
         chk("pixel_x_a", 32'(if_a.pixel_x), 32'(k % HT));
         chk("pixel_y_a", 32'(if_a.pixel_y), 32'((k / HT) % VT));
         chk("pixel_x_b", 32'(if_b.pixel_x), 32'(k % HT));
         chk("display_on_a", 32'(if_a.display_on), 32'((k % HT) < 16 && ((k / HT) % VT) < 8));
         chk("vblank_a", 32'(if_a.vblank_pulse), 32'((k % FRAME) == 256));
         chk("vblank_b", 32'(if_b.vblank_pulse), 32'((k % FRAME) == 256));
         if (k == 0) begin
            chk("release_pins_a", 32'({hs_a, vs_a, rgb_a}), 32'h18);
            chk("release_pins_b", 32'({hs_b, vs_b, rgb_b}), 32'h18);
         end else if (q.size() != 0 && q[0].due == k) begin
            cur = q.pop_front();
            chk("pins_a", 32'({hs_a, vs_a, rgb_a}), 32'(cur.ea));
            chk("pins_b", 32'({hs_b, vs_b, rgb_b}), 32'(cur.eb));
         end else begin
            checks++;
            failures++;
            $display("FAIL sb_entry k=%0d actual=missing expected=entry_due_%0d", k, k);
         end
         if (hs_a_prev && !hs_a && fall_a < 0) fall_a = k;
         if (hs_b_prev && !hs_b && fall_b < 0) fall_b = k;
         hs_a_prev = hs_a;
         hs_b_prev = hs_b;
         if (k >= 3 && k < 3 + FRAME) begin
            if (!hs_a) hs_low_a++;
            if (!vs_a) vs_low_a++;
         end
         if (if_a.vblank_pulse) vb_cnt++;
         if (rgb_a == 3'd5) begin
            five_cnt++;
            five_k = k;
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      run      = 1'b0;
      mode     = 2;
      k        = 0;
      if_a.rgb_en = 1'b0;
      if_a.rgb    = 3'd0;
      if_b.rgb_en = 1'b0;
      if_b.rgb    = 3'd0;
      reset    = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_pins("por");
      chk("por_display_on", 32'(if_a.display_on), 1);

      // Three frames with no pipeline hits: sync timing, vblank count, background colour
      start_phase(2);
      repeat (3 * FRAME) step();
      chk("vblank_count", vb_cnt, 3);
      chk("hsync_first_fall_a", fall_a, 23);
      chk("hsync_first_fall_b", fall_b, 21);
      chk("hsync_low_per_frame_a", hs_low_a, 15 * 6);
      chk("vsync_low_per_frame_a", vs_low_a, 2 * HT);

      // Single hit at (5,3): exactly one colour-5 pixel, 3 clocks after issue
      run   = 1'b0;
      reset = 1'b0;
      start_phase(0);
      repeat (FRAME + 10) step();
      chk("hit_count", five_cnt, 1);
      chk("hit_clock", five_k, 3 * HT + 5 + 3);

      // Constant rgb_en with a mid-frame reset while hsync is low
      run   = 1'b0;
      reset = 1'b0;
      start_phase(1);
      repeat (185) step();
      #2;
      chk("pre_reset_hsync_a", 32'(hs_a), 0);
      run   = 1'b0;
      reset = 1'b0;
      #1;
      chk_reset_pins("async_rst");
      repeat (5) @(posedge clk);
      #1;
      chk_reset_pins("held_rst");
      start_phase(1);
      repeat (FRAME + 5) step();
      run = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
